// File: rtl/sccb_pkg.sv
// Shared constants and state types for the SCCB register-init sequencer.
// Register offsets match the SCCB APB slave's map.
package sccb_pkg;

    localparam logic [7:0] IDADDR_RW_REG = 8'h00;
    localparam logic [7:0] SUBADDR_REG   = 8'h04;
    localparam logic [7:0] WDATA_REG     = 8'h08;
    localparam logic [7:0] START_REG     = 8'h10;
    localparam logic [7:0] DONE_REG      = 8'h14;

    localparam logic [15:0] END_MARK  = 16'hFFFF;
    localparam logic [7:0]  DELAY_TAG = 8'hFE;
    localparam logic [7:0]  START_CMD = 8'h01;
    localparam logic [7:0]  DONE_MASK = 8'h01;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_SLVERR  = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_code_e;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LOAD, S_DECODE, S_WRITE,
        S_POLL, S_DELAY, S_NEXT, S_FINISH, S_FAIL
    } seq_state_e;

    typedef enum logic [1:0] {
        X_IDLE, X_SETUP, X_ACCESS
    } xfer_state_e;

endpackage

// File: rtl/sccb_init_sequencer_if.sv
// APB bus between the init sequencer (master) and the SCCB APB slave.
interface sccb_init_sequencer_if;

    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/sccb_init_sequencer_apb_master_xfer.sv
// Single APB transfer engine: SETUP then ACCESS until PREADY; ack marks the
// completion cycle, with rdata/slverr valid alongside it.
module apb_master_xfer
    import sccb_pkg::*;
(
    input  logic                         PCLK,
    input  logic                         PRESETN,
    input  logic                         req,
    input  logic                         wr,
    input  logic [7:0]                   addr,
    input  logic [7:0]                   wdata,
    output logic                         ack,
    output logic [7:0]                   rdata,
    output logic                         slverr,
    sccb_init_sequencer_if.master        apb
);

    xfer_state_e state, state_nxt;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // register samples pre-edge values regardless of process order.
        if (!PRESETN) state <= X_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        // NOTE: assigning a default first guarantees no path leaves the
        // signal unassigned, which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            X_IDLE:   if (req) state_nxt = X_SETUP;
            X_SETUP:  state_nxt = X_ACCESS;
            X_ACCESS: if (apb.PREADY) state_nxt = X_IDLE;
            default:  state_nxt = X_IDLE;
        endcase
    end

    // Address phase is latched at request so it holds through wait states.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            apb.PADDR  <= '0;
            apb.PWDATA <= '0;
            apb.PWRITE <= 1'b0;
        end else if (state == X_IDLE && req) begin
            apb.PADDR  <= addr;
            apb.PWDATA <= wdata;
            apb.PWRITE <= wr;
        end
    end

    assign apb.PSEL    = (state != X_IDLE);
    assign apb.PENABLE = (state == X_ACCESS);
    assign ack         = (state == X_ACCESS) && apb.PREADY;
    assign rdata       = apb.PRDATA;
    assign slverr      = apb.PSLVERR;

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks a register-init table and programs the camera through the SCCB APB
// slave: four writes per entry, then DONE polling; supports delays and end marks.
module sccb_init_sequencer
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ID      = 8'h42,
    parameter int         TBL_AW      = 8,
    parameter int         DELAY_TICKS = 50000,
    parameter int         POLL_MAX    = 1024
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  start,
    output logic [TBL_AW-1:0]     tbl_addr,
    input  logic [15:0]           tbl_data,
    sccb_init_sequencer_if.master apb,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [TBL_AW-1:0]     err_index
);

    localparam int DW = 8 + $clog2(DELAY_TICKS);
    localparam int PW = $clog2(POLL_MAX + 1);
    typedef logic [DW-1:0] dly_t;
    typedef logic [PW-1:0] poll_t;

    seq_state_e        state, state_nxt;
    logic [TBL_AW-1:0] index;
    logic [15:0]       entry;
    logic [1:0]        step;
    dly_t              delay_cnt;
    poll_t             poll_cnt;
    err_code_e         err_q;

    logic       xfer_req, xfer_wr, xfer_ack, xfer_slverr;
    logic [7:0] xfer_addr, xfer_wdata, xfer_rdata;
    logic       poll_done, poll_last;

    assign poll_done = (xfer_rdata & DONE_MASK) != 8'h00;
    assign poll_last = (poll_cnt == poll_t'(POLL_MAX - 1));

    apb_master_xfer u_xfer (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .req     (xfer_req),
        .wr      (xfer_wr),
        .addr    (xfer_addr),
        .wdata   (xfer_wdata),
        .ack     (xfer_ack),
        .rdata   (xfer_rdata),
        .slverr  (xfer_slverr),
        .apb     (apb)
    );

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        xfer_req   = 1'b0;
        xfer_wr    = 1'b0;
        xfer_addr  = '0;
        xfer_wdata = '0;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_DECODE;
            S_DECODE: begin
                if (entry == END_MARK)            state_nxt = S_FINISH;
                else if (entry[15:8] == DELAY_TAG) state_nxt = (entry[7:0] == 8'h00) ? S_NEXT : S_DELAY;
                else                               state_nxt = S_WRITE;
            end
            S_WRITE: begin
                xfer_req = 1'b1;
                xfer_wr  = 1'b1;
                case (step)
                    2'd0:    begin xfer_addr = IDADDR_RW_REG; xfer_wdata = DEV_ID;      end
                    2'd1:    begin xfer_addr = SUBADDR_REG;   xfer_wdata = entry[15:8]; end
                    2'd2:    begin xfer_addr = WDATA_REG;     xfer_wdata = entry[7:0];  end
                    default: begin xfer_addr = START_REG;     xfer_wdata = START_CMD;   end
                endcase
                if (xfer_ack) begin
                    if (xfer_slverr)       state_nxt = S_FAIL;
                    else if (step == 2'd3) state_nxt = S_POLL;
                end
            end
            S_POLL: begin
                xfer_req  = 1'b1;
                xfer_addr = DONE_REG;
                if (xfer_ack) begin
                    if (xfer_slverr)    state_nxt = S_FAIL;
                    else if (poll_done) state_nxt = S_NEXT;
                    else if (poll_last) state_nxt = S_FAIL;
                end
            end
            // Leaving at a count of one gives exactly data x DELAY_TICKS cycles here.
            S_DELAY:  if (delay_cnt == dly_t'(1)) state_nxt = S_NEXT;
            S_NEXT:   state_nxt = (index == '1) ? S_FINISH : S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            index     <= '0;
            entry     <= '0;
            step      <= '0;
            delay_cnt <= '0;
            poll_cnt  <= '0;
            error     <= 1'b0;
            err_q     <= ERR_NONE;
            err_index <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    index <= '0;
                    error <= 1'b0;
                    err_q <= ERR_NONE;
                end
                S_LOAD:   entry <= tbl_data;
                S_DECODE: begin
                    step      <= '0;
                    poll_cnt  <= '0;
                    delay_cnt <= dly_t'(entry[7:0]) * dly_t'(DELAY_TICKS);
                end
                S_WRITE: if (xfer_ack) begin
                    if (xfer_slverr) begin
                        err_q     <= ERR_SLVERR;
                        err_index <= index;
                    end else begin
                        step <= step + 2'd1;
                    end
                end
                S_POLL: if (xfer_ack) begin
                    if (xfer_slverr) begin
                        err_q     <= ERR_SLVERR;
                        err_index <= index;
                    end else if (!poll_done) begin
                        if (poll_last) begin
                            err_q     <= ERR_TIMEOUT;
                            err_index <= index;
                        end else begin
                            poll_cnt <= poll_cnt + poll_t'(1);
                        end
                    end
                end
                S_DELAY: delay_cnt <= delay_cnt - dly_t'(1);
                S_NEXT:  if (index != '1) index <= index + TBL_AW'(1);
                S_FAIL:  error <= 1'b1;
                default: ;
            endcase
        end
    end

    assign tbl_addr = index;
    assign err_code = err_q;
    assign done     = (state == S_FINISH);
    assign busy     = (state != S_IDLE) && (state != S_FINISH) && (state != S_FAIL);

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Scoreboard bench: a table-walking reference model queues the expected APB
// transfers and outcome; a bus monitor pops and compares each completed transfer.
module tb_sccb_init_sequencer;
    import sccb_pkg::*;

    localparam int         AW    = 2;
    localparam int         DEPTH = 4;
    localparam int         TICKS = 4;
    localparam int         PMAX  = 8;
    localparam logic [7:0] DEV   = 8'h42;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } xfer_t;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [AW-1:0] tbl_addr, err_index;
    logic [15:0]   tbl_data = '0;
    logic          busy, done, error;
    logic [1:0]    err_code;

    sccb_init_sequencer_if apb ();

    sccb_init_sequencer #(
        .DEV_ID(DEV), .TBL_AW(AW), .DELAY_TICKS(TICKS), .POLL_MAX(PMAX)
    ) dut (
        .PCLK(clk), .PRESETN(rst_n), .start(start),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .apb(apb),
        .busy(busy), .done(done), .error(error),
        .err_code(err_code), .err_index(err_index)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    logic [15:0] tbl [DEPTH];
    int          da [8];          // DONE returned on this read of the nth programmed entry (0 = never)
    int          err_at = 0;      // global transfer number answered with PSLVERR (0 = none)
    int          force_wait_at = 0, force_wait_len = 0;

    xfer_t         exp_q [$];
    bit            exp_err;
    logic [1:0]    exp_code;
    logic [AW-1:0] exp_idx;
    int            m_n;

    bit mon_en = 1'b0;
    int done_cnt = 0, sub_pen = 0;
    int dwell [DEPTH];

    int            xfer_n = 0, nth_s = 0, polls_s = 0, wait_left = 0, cur_wait = 0;
    logic [AW-1:0] addr_q = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: walk the table by the sequencer's rules.
    function automatic bit m_issue(input logic wr, input logic [7:0] a, input logic [7:0] d, input int idx);
        xfer_t x;
        x = '{wr, a, d};
        exp_q.push_back(x);
        m_n++;
        if (m_n == err_at) begin
            exp_err  = 1'b1;
            exp_code = 2'b01;
            exp_idx  = idx[AW-1:0];
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_run();
        int nth = 0;
        bit stop = 1'b0;
        m_n = 0;
        exp_q.delete();
        exp_err = 1'b0; exp_code = 2'b00; exp_idx = '0;
        for (int i = 0; i < DEPTH && !stop; i++) begin
            if (tbl[i] == 16'hFFFF) stop = 1'b1;
            else if (tbl[i][15:8] != 8'hFE) begin
                stop = m_issue(1'b1, 8'h00, DEV, i) || m_issue(1'b1, 8'h04, tbl[i][15:8], i) ||
                       m_issue(1'b1, 8'h08, tbl[i][7:0], i) || m_issue(1'b1, 8'h10, 8'h01, i);
                for (int p = 1; p <= PMAX && !stop; p++) begin
                    if (m_issue(1'b0, 8'h14, 8'h00, i)) stop = 1'b1;
                    else if (da[nth] == p) break;
                    else if (p == PMAX) begin
                        exp_err = 1'b1; exp_code = 2'b10; exp_idx = i[AW-1:0]; stop = 1'b1;
                    end
                end
                nth++;
            end
        end
    endtask

    // Table ROM (data one cycle after address) and APB slave responder.
    initial begin
        apb.PREADY = 1'b0; apb.PRDATA = '0; apb.PSLVERR = 1'b0;
        forever begin
            @(posedge clk); #1;
            tbl_data = tbl[addr_q];
            addr_q   = tbl_addr;
            apb.PREADY = 1'b0; apb.PSLVERR = 1'b0;
            if (apb.PSEL && !apb.PENABLE) begin
                wait_left = (xfer_n + 1 == force_wait_at) ? force_wait_len : int'($urandom_range(0, 2));
                cur_wait  = wait_left;
            end else if (apb.PSEL && apb.PENABLE) begin
                if (wait_left > 0) wait_left--;
                else begin
                    apb.PREADY = 1'b1;
                    xfer_n++;
                    apb.PSLVERR = (xfer_n == err_at);
                    apb.PRDATA  = 8'($urandom) & 8'hFE;
                    if (apb.PWRITE && apb.PADDR == 8'h10) begin nth_s++; polls_s = 0; end
                    if (!apb.PWRITE) begin
                        polls_s++;
                        if (nth_s > 0 && da[nth_s-1] == polls_s) apb.PRDATA[0] = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: compares completed transfers against the expected queue.
    logic [7:0] s_addr, s_data;
    logic       s_wr;
    bit         stable;
    int         pen_cnt;
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (busy) dwell[tbl_addr]++;
            if (done) begin
                done_cnt++;
                check("busy_low_with_done", busy, 0);
            end
            if (apb.PSEL && !apb.PENABLE) begin
                s_addr = apb.PADDR; s_data = apb.PWDATA; s_wr = apb.PWRITE;
                pen_cnt = 0; stable = 1'b1;
            end
            if (apb.PSEL && apb.PENABLE) begin
                pen_cnt++;
                if ({apb.PWRITE, apb.PADDR, apb.PWDATA} != {s_wr, s_addr, s_data}) stable = 1'b0;
                if (apb.PREADY) begin
                    check("hold_stable", stable, 1);
                    check("penable_cycles", pen_cnt, cur_wait + 1);
                    if (apb.PADDR == 8'h04) sub_pen = pen_cnt;
                    check("xfer_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        xfer_t e;
                        e = exp_q.pop_front();
                        check("xfer_dir_addr", {apb.PWRITE, apb.PADDR}, {e.wr, e.addr});
                        if (e.wr) check("xfer_wdata", apb.PWDATA, e.data);
                    end
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check(tag, {busy, done, error, err_code, err_index, tbl_addr, apb.PSEL, apb.PENABLE,
                    apb.PWRITE, apb.PADDR, apb.PWDATA}, 0);
    endtask

    task automatic run_seq(input string tag, input bit mid_start);
        bit ended = 1'b0;
        model_run();
        xfer_n = 0; nth_s = 0; polls_s = 0; done_cnt = 0;
        for (int i = 0; i < DEPTH; i++) dwell[i] = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_error_cleared"}, error, 0);
        check({tag, "_busy_high"}, busy, 1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (mid_start && cyc == 6) begin
                start = 1'b1; @(negedge clk); start = 1'b0;
            end else begin
                @(negedge clk);
            end
            if (!busy) begin ended = 1'b1; break; end
        end
        check({tag, "_ended_in_time"}, ended, 1);
        repeat (2) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt, exp_err ? 0 : 1);
        check({tag, "_error"}, error, exp_err);
        check({tag, "_err_code"}, err_code, exp_code);
        if (exp_err) check({tag, "_err_index"}, err_index, exp_idx);
        check({tag, "_left_over_xfers"}, exp_q.size(), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        for (int i = 0; i < DEPTH; i++) tbl[i] = 16'hFFFF;
        for (int i = 0; i < 8; i++) da[i] = 1;

        repeat (3) @(negedge clk);
        check_reset_vals("reset_values");
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Basic two-entry table, start pulsed again while busy.
        tbl[0] = 16'h1280; tbl[1] = 16'h1101; tbl[2] = 16'hFFFF; tbl[3] = 16'h0000;
        run_seq("basic", 1'b1);

        // Delay entries: the FE03 entry dwells 3*TICKS cycles longer than FE00.
        tbl[0] = 16'hFE00; tbl[1] = 16'hFE03; tbl[2] = 16'hFE00; tbl[3] = 16'hFFFF;
        run_seq("delay", 1'b0);
        check("delay_extra_cycles", dwell[1] - dwell[2], 3 * TICKS);

        // PREADY held low 3 cycles on the SUBADDR write.
        tbl[0] = 16'h1234; tbl[1] = 16'hFFFF;
        force_wait_at = 2; force_wait_len = 3;
        run_seq("wait_states", 1'b0);
        check("subaddr_penable_cycles", sub_pen, force_wait_len + 1);
        force_wait_at = 0;

        // PSLVERR on the START write of entry 2.
        tbl[0] = 16'h0101; tbl[1] = 16'h0202; tbl[2] = 16'h0303; tbl[3] = 16'hFFFF;
        err_at = 14;
        run_seq("slverr", 1'b0);
        err_at = 0;

        // DONE never set: poll timeout after PMAX reads.
        tbl[0] = 16'h3344; tbl[1] = 16'hFFFF;
        da[0] = 0;
        run_seq("timeout", 1'b0);
        da[0] = 1;

        // No end marker: all four entries then done.
        tbl[0] = 16'h1111; tbl[1] = 16'hFE01; tbl[2] = 16'h2222; tbl[3] = 16'h3333;
        run_seq("no_end_mark", 1'b0);

        // Reset asserted during an ACCESS phase.
        tbl[0] = 16'h1280; tbl[1] = 16'hFFFF;
        model_run();
        xfer_n = 0; nth_s = 0; polls_s = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            @(negedge clk);
            if (apb.PSEL && apb.PENABLE) seen = 1'b1;
        end
        check("access_reached", seen, 1);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("reset_mid_access");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        @(negedge clk);

        // Randomized tables, poll counts, wait states and error injection.
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < DEPTH; i++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 1)      tbl[i] = 16'hFFFF;
                else if (r < 3) tbl[i] = {8'hFE, 8'($urandom_range(0, 2))};
                else            tbl[i] = {8'($urandom_range(0, 8'hFD)), 8'($urandom)};
            end
            for (int k = 0; k < 8; k++) da[k] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
            err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
            run_seq("random", 1'b0);
        end
        err_at = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sccb_init_sequencer.md
Name: sccb_init_sequencer

Overview:
- APB master that walks a register-init table and programs the camera over the SCCB APB slave, one register per table entry.
- Sits between a table store (ROM/RAM) and the SCCB APB slave, in the same PCLK domain.
- For each entry it writes the device ID, sub-address and data, issues START, then polls DONE.
- Supports delay entries and end-of-table markers, and reports completion, errors and poll timeouts.

Parameters:
- DEV_ID, 8'h42, SCCB write ID written to IDADDR_RW_REG (bit0 = 0 for write).
- TBL_AW, 8, table index width; depth is 2**TBL_AW.
- DELAY_TICKS, 50000, PCLK cycles per delay unit (1 ms at 50 MHz).
- POLL_MAX, 1024, maximum DONE reads per entry before timeout.
- IDADDR_RW_REG / SUBADDR_REG / WDATA_REG / START_REG / DONE_REG, 0 / 4 / 8 / 16 / 20, slave register offsets.

Ports:
- PCLK  in  1  clock.
- PRESETN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins the sequence at index 0 when idle.
- tbl_addr  out  TBL_AW  table index.
- tbl_data  in  16  {subaddr[15:8], data[7:0]}; valid exactly one cycle after tbl_addr changes.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  8  APB address.
- PWDATA  out  8  APB write data.
- PRDATA  in  8  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky; cleared by the next accepted start.
- err_code  out  2  00 none, 01 PSLVERR, 10 poll timeout.
- err_index  out  TBL_AW  index of the failing entry.

Behaviour:
- Reset values:
  - PSEL, PENABLE, PWRITE, busy, done, error = 0.
  - PADDR, PWDATA, tbl_addr, err_code, err_index = 0.
  - FSM in IDLE.
- IDLE:
  - start accepted: index = 0, busy = 1, error and err_code cleared, go to FETCH.
  - start while busy is ignored.
- FETCH: drive tbl_addr = index; wait one cycle; capture tbl_data; go to DECODE.
- DECODE:
  - 16'hFFFF: end of table → FINISH.
  - 8'hFE in the high byte: delay → DELAY, counter = data × DELAY_TICKS. data = 0 skips straight to NEXT.
  - Otherwise: issue four APB writes in order:
    - IDADDR_RW_REG = DEV_ID
    - SUBADDR_REG = subaddr
    - WDATA_REG = data
    - START_REG = 8'h01
  - After the four writes, go to POLL.
- APB transfer (shared sub-sequence):
  - SETUP: PSEL = 1, PENABLE = 0, with PADDR, PWRITE and PWDATA stable.
  - ACCESS: PENABLE = 1; hold all signals until PREADY = 1.
  - Completion cycle: PSEL and PENABLE drop the cycle after PREADY. Back-to-back transfers still insert a SETUP cycle.
  - PSLVERR = 1 with PREADY: err_code = 01, err_index = index → FAIL. Any remaining writes are not issued.
- POLL:
  - APB read of DONE_REG; a poll counter increments per read.
  - PRDATA[0] = 1 → NEXT.
  - If POLL_MAX reads complete without DONE: err_code = 10 → FAIL.
  - PSLVERR on a poll read is handled as in the APB transfer rule.
- DELAY: decrement the counter each cycle; at 0 → NEXT.
- NEXT:
  - index = 2**TBL_AW − 1 (last index): → FINISH; no wrap.
  - Otherwise index + 1 → FETCH.
- FINISH: done pulses for one cycle, busy = 0 → IDLE.
- FAIL: error = 1, busy = 0, done stays 0 → IDLE.
- PRESETN asserted mid-transfer: all outputs return to reset values immediately, with no bus hold.
- Counter widths:
  - Delay counter: 8 + clog2(DELAY_TICKS) bits.
  - Poll counter: clog2(POLL_MAX + 1) bits.

Decomposition:
- Shared package sccb_pkg holds:
  - register offset constants;
  - END_MARK = 16'hFFFF and DELAY_TAG = 8'hFE;
  - err_code encodings;
  - FSM state enum.
- One sub-module, apb_master_xfer:
  - inputs req, wr, addr, wdata;
  - outputs ack, rdata, slverr;
  - owns the SETUP/ACCESS handshake.
- The top-level sequencer FSM drives apb_master_xfer.

Test Plan:
- Table {0x1280, 0x1101, 0xFFFF}, slave returns DONE = 1 on the first read → exact APB sequence (0x00 = 0x42, 0x04 = 0x12, 0x08 = 0x80, 0x10 = 0x01, read 0x14), then the same sequence for 0x11/0x01; done pulses once and busy falls the same cycle.
- Entry 0xFE03 with DELAY_TICKS = 4 → exactly 12 cycles with PSEL = 0 between the end-of-FETCH decode and the next FETCH.
- PREADY held low 3 cycles on the SUBADDR write → PENABLE is high for 4 cycles, PADDR/PWDATA stay stable, no duplicate transfer.
- PSLVERR on the START write of entry 2 → error = 1, err_code = 01, err_index = 2, no DONE read is issued, and a following start clears error.
- DONE never set, POLL_MAX = 8 → exactly 8 reads of 0x14, then err_code = 10 and busy = 0.
- PRESETN pulsed during an ACCESS phase → all outputs are 0 within the reset; start pulsed while busy has no effect; TBL_AW = 2 with no end marker → 4 entries processed, then done.
